// File: rtl/glb_multicast_issuer_if.sv
// rtl/glb_multicast_issuer_if.sv - shared single-port GLB read bus
// The issuer drives bank/address/enable; the GLB returns data one cycle after o_glb_re.
interface glb_multicast_issuer_if #(
   parameter int BSW           = 2,
   parameter int AW            = 9,
   parameter int DATA_BITWIDTH = 32
);
   logic [BSW-1:0]           o_glb_bank_sel;
   logic                     o_glb_re;
   logic [AW-1:0]            o_glb_ra;
   logic [DATA_BITWIDTH-1:0] i_glb_rd;

   modport master (output o_glb_bank_sel, output o_glb_re, output o_glb_ra, input i_glb_rd);
   modport slave  (input o_glb_bank_sel, input o_glb_re, input o_glb_ra, output i_glb_rd);
endinterface

// File: rtl/glb_multicast_issuer.sv
// rtl/glb_multicast_issuer.sv - multi-channel GLB-to-NoC read streamer
// Round-robin shares one GLB read port among channels, each feeding a credit-gated output FIFO.
module glb_multicast_issuer #(
   parameter int CH_NUM          = 3,
   parameter int DATA_BITWIDTH   = 32,
   parameter int BANK_NUM        = 3,
   parameter int BANK_DEPTH      = 512,
   parameter int ROW_ID_BITWIDTH = 4,
   parameter int COL_ID_BITWIDTH = 5,
   parameter int LEN_BITWIDTH    = 10,
   parameter int FIFO_DEPTH      = 4,
   localparam int BSW = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1,
   localparam int AW  = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1,
   localparam int PKW = ROW_ID_BITWIDTH + COL_ID_BITWIDTH
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic [0:CH_NUM-1]                 i_start,
   input  logic [0:CH_NUM*BSW-1]             i_bank,
   input  logic [0:CH_NUM*AW-1]              i_base_addr,
   input  logic [0:CH_NUM*LEN_BITWIDTH-1]    i_len,
   input  logic [0:CH_NUM*PKW-1]             i_packet,
   glb_multicast_issuer_if.master            glb,
   output logic [0:CH_NUM*DATA_BITWIDTH-1]   o_data,
   output logic [0:CH_NUM*PKW-1]             o_packet,
   output logic [0:CH_NUM-1]                 o_valid,
   input  logic [0:CH_NUM-1]                 i_ready,
   output logic [0:CH_NUM-1]                 o_busy,
   output logic [0:CH_NUM-1]                 o_done
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int OW = $clog2(FIFO_DEPTH + 1);
   localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

   typedef enum logic {IDLE, RUN} state_e;

   state_e                    state_q  [CH_NUM];
   logic [BSW-1:0]            bank_q   [CH_NUM];
   logic [AW-1:0]             base_q   [CH_NUM];
   logic [LEN_BITWIDTH-1:0]   len_q    [CH_NUM];
   logic [LEN_BITWIDTH-1:0]   issued_q [CH_NUM];
   logic [LEN_BITWIDTH-1:0]   popped_q [CH_NUM];
   logic [PKW-1:0]            pkt_q    [CH_NUM];
   logic [DATA_BITWIDTH-1:0]  mem_q    [CH_NUM][FIFO_DEPTH];
   logic [PW-1:0]             wptr_q   [CH_NUM];
   logic [PW-1:0]             rptr_q   [CH_NUM];
   logic [OW-1:0]             occ_q    [CH_NUM];
   logic [0:CH_NUM-1]         done_q;
   logic                      rsp_vld_q;
   logic [CW-1:0]             rsp_ch_q;
   logic [CW-1:0]             rr_q;
   logic [BSW-1:0]            bank_sel_q;
   logic [AW-1:0]             ra_q;

   logic [CH_NUM-1:0]         elig_d;
   logic [CH_NUM-1:0]         push_d;
   logic [CH_NUM-1:0]         pop_d;
   logic                      grant_vld_d;
   logic [CW-1:0]             grant_ch_d;
   logic [AW-1:0]             grant_addr_d;

   // Credit counts only registered occupancy plus the in-flight read, so i_ready never reaches o_glb_re.
   always_comb begin
      int idx;
      idx          = 0;
      elig_d       = '0;
      push_d       = '0;
      pop_d        = '0;
      grant_vld_d  = 1'b0;
      grant_ch_d   = rr_q;
      grant_addr_d = '0;
      for (int c = 0; c < CH_NUM; c++) begin
         push_d[c] = rsp_vld_q && (rsp_ch_q == CW'(c));
         pop_d[c]  = (occ_q[c] != '0) && i_ready[c];
         elig_d[c] = (state_q[c] == RUN) && (issued_q[c] < len_q[c]) &&
                     ((int'(occ_q[c]) + int'(push_d[c])) < FIFO_DEPTH);
      end
      // rr_q names the channel after the last grant; scan downwards so the nearest one wins.
      for (int k = CH_NUM - 1; k >= 0; k--) begin
         idx = (int'(rr_q) + k) % CH_NUM;
         if (elig_d[idx]) begin
            grant_vld_d = 1'b1;
            grant_ch_d  = CW'(idx);
         end
      end
      grant_addr_d = base_q[grant_ch_d] + AW'(issued_q[grant_ch_d]);
   end

   assign glb.o_glb_re       = grant_vld_d;
   assign glb.o_glb_ra       = grant_vld_d ? grant_addr_d : ra_q;
   assign glb.o_glb_bank_sel = grant_vld_d ? bank_q[grant_ch_d] : bank_sel_q;
   assign o_done             = done_q;

   always_comb begin
      o_data   = '0;
      o_packet = '0;
      o_valid  = '0;
      o_busy   = '0;
      for (int c = 0; c < CH_NUM; c++) begin
         o_valid[c] = (occ_q[c] != '0);
         o_busy[c]  = (state_q[c] == RUN);
         if (occ_q[c] != '0) begin
            o_data[c*DATA_BITWIDTH +: DATA_BITWIDTH] = mem_q[c][rptr_q[c]];
            o_packet[c*PKW +: PKW]                   = pkt_q[c];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      for (int c = 0; c < CH_NUM; c++) begin
         if (push_d[c]) mem_q[c][wptr_q[c]] <= glb.i_glb_rd;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int c = 0; c < CH_NUM; c++) begin
            state_q[c]  <= IDLE;
            bank_q[c]   <= '0;
            base_q[c]   <= '0;
            len_q[c]    <= '0;
            issued_q[c] <= '0;
            popped_q[c] <= '0;
            pkt_q[c]    <= '0;
            wptr_q[c]   <= '0;
            rptr_q[c]   <= '0;
            occ_q[c]    <= '0;
         end
         done_q     <= '0;
         rsp_vld_q  <= 1'b0;
         rsp_ch_q   <= '0;
         rr_q       <= '0;
         bank_sel_q <= '0;
         ra_q       <= '0;
      end else begin
         rsp_vld_q <= grant_vld_d;
         rsp_ch_q  <= grant_ch_d;
         if (grant_vld_d) begin
            rr_q       <= (grant_ch_d == CW'(CH_NUM - 1)) ? '0 : grant_ch_d + 1'b1;
            bank_sel_q <= bank_q[grant_ch_d];
            ra_q       <= grant_addr_d;
         end
         for (int c = 0; c < CH_NUM; c++) begin
            done_q[c] <= 1'b0;
            if (push_d[c]) wptr_q[c] <= (wptr_q[c] == PW'(FIFO_DEPTH - 1)) ? '0 : wptr_q[c] + 1'b1;
            if (pop_d[c])  rptr_q[c] <= (rptr_q[c] == PW'(FIFO_DEPTH - 1)) ? '0 : rptr_q[c] + 1'b1;
            occ_q[c] <= occ_q[c] + OW'(push_d[c]) - OW'(pop_d[c]);
            case (state_q[c])
               IDLE: begin
                  if (i_start[c]) begin
                     bank_q[c]   <= i_bank[c*BSW +: BSW];
                     base_q[c]   <= i_base_addr[c*AW +: AW];
                     len_q[c]    <= i_len[c*LEN_BITWIDTH +: LEN_BITWIDTH];
                     pkt_q[c]    <= i_packet[c*PKW +: PKW];
                     issued_q[c] <= '0;
                     popped_q[c] <= '0;
                     if (i_len[c*LEN_BITWIDTH +: LEN_BITWIDTH] == '0) done_q[c] <= 1'b1;
                     else                                             state_q[c] <= RUN;
                  end
               end
               RUN: begin
                  if (grant_vld_d && (grant_ch_d == CW'(c))) issued_q[c] <= issued_q[c] + 1'b1;
                  if (pop_d[c]) begin
                     popped_q[c] <= popped_q[c] + 1'b1;
                     if (popped_q[c] == len_q[c] - 1'b1) begin
                        done_q[c]  <= 1'b1;
                        state_q[c] <= IDLE;
                     end
                  end
               end
               default: state_q[c] <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_glb_multicast_issuer.sv
// tb/tb_glb_multicast_issuer.sv - self-checking bench for glb_multicast_issuer
// Transfer-level model (expected word queues per channel) checked every cycle, plus literal timing checks.
module tb_glb_multicast_issuer;
   localparam int CH = 3, DW = 32, BSW = 2, AW = 9, LW = 10, PKW = 9, FD = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst_q = 1'b0;
   logic [0:CH-1]      start = '0;
   logic [0:CH*BSW-1]  bank_bus = '0;
   logic [0:CH*AW-1]   base_bus = '0;
   logic [0:CH*LW-1]   len_bus = '0;
   logic [0:CH*PKW-1]  pkt_bus = '0;
   logic [0:CH*DW-1]   data_o;
   logic [0:CH*PKW-1]  pkt_o;
   logic [0:CH-1]      valid, busy, done;
   logic [0:CH-1]      ready = '1;

   int errors = 0;
   int checks = 0;

   glb_multicast_issuer_if #(.BSW(BSW), .AW(AW), .DATA_BITWIDTH(DW)) gif ();

   glb_multicast_issuer dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_bank(bank_bus), .i_base_addr(base_bus),
      .i_len(len_bus), .i_packet(pkt_bus), .glb(gif), .o_data(data_o), .o_packet(pkt_o),
      .o_valid(valid), .i_ready(ready), .o_busy(busy), .o_done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) rst_q <= rst;

   function automatic logic [31:0] mem_word(int b, int a);
      return {4'hA, 4'(b), 15'h0, 9'(a)};
   endfunction

   // GLB with 1-cycle read latency; garbage when not reading.
   always @(posedge clk) gif.i_glb_rd <= gif.o_glb_re ? mem_word(int'(gif.o_glb_bank_sel), int'(gif.o_glb_ra)) : 32'hDEADBEEF;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Transfer-level model
   logic [31:0]  exp_q [CH][$];
   int           iss_q [CH][$];
   logic [8:0]   m_pkt [CH];
   bit           m_busy [CH];
   bit           m_done [CH];
   int           issued_cnt [CH];
   int           popped_cnt [CH];
   logic [AW-1:0]  last_ra = '0;
   logic [BSW-1:0] last_bank = '0;
   int           grant_log[$];
   int           ra_log[$];

   initial for (int c = 0; c < CH; c++) begin
      m_busy[c] = 0; m_done[c] = 0; m_pkt[c] = '0; issued_cnt[c] = 0; popped_cnt[c] = 0;
   end

   always @(negedge clk) begin
      int key;
      int hit;
      bit was_busy;
      bit done_n;
      int len_c, base_c, bank_c;
      if (rst_q) begin
         chk("reset_ctrl", {valid, busy, done, gif.o_glb_re}, '0);
         chk("reset_data", {data_o, pkt_o}, '0);
         chk("reset_glb_addr", {gif.o_glb_bank_sel, gif.o_glb_ra}, '0);
      end else begin
         for (int c = 0; c < CH; c++) begin
            chk($sformatf("busy%0d", c), busy[c], m_busy[c]);
            chk($sformatf("done%0d", c), done[c], m_done[c]);
            chk($sformatf("valid_nodata%0d", c), valid[c] && (exp_q[c].size() == 0), 1'b0);
            if (valid[c] && exp_q[c].size() > 0) begin
               chk($sformatf("data%0d", c), data_o[c*DW +: DW], exp_q[c][0]);
               chk($sformatf("pkt%0d", c), pkt_o[c*PKW +: PKW], m_pkt[c]);
            end
         end
         if (gif.o_glb_re) begin
            key = int'(gif.o_glb_bank_sel) * 1024 + int'(gif.o_glb_ra);
            hit = -1;
            for (int c = CH - 1; c >= 0; c--)
               if (iss_q[c].size() > 0 && iss_q[c][0] == key) hit = c;
            chk("read_expected", hit >= 0, 1'b1);
            if (hit >= 0) begin
               void'(iss_q[hit].pop_front());
               issued_cnt[hit]++;
               chk("credit", (issued_cnt[hit] - popped_cnt[hit]) <= FD, 1'b1);
               grant_log.push_back(hit);
            end
            ra_log.push_back(int'(gif.o_glb_ra));
            last_ra = gif.o_glb_ra;
            last_bank = gif.o_glb_bank_sel;
         end else begin
            chk("glb_addr_hold", {gif.o_glb_bank_sel, gif.o_glb_ra}, {last_bank, last_ra});
         end
      end
      // advance the model to the next cycle
      if (rst) begin
         for (int c = 0; c < CH; c++) begin
            exp_q[c].delete(); iss_q[c].delete();
            m_busy[c] = 0; m_done[c] = 0; issued_cnt[c] = 0; popped_cnt[c] = 0;
         end
         last_ra = '0; last_bank = '0;
      end else begin
         for (int c = 0; c < CH; c++) begin
            was_busy = m_busy[c];
            done_n = 0;
            if (valid[c] && ready[c] && exp_q[c].size() > 0) begin
               void'(exp_q[c].pop_front());
               popped_cnt[c]++;
               if (exp_q[c].size() == 0) begin done_n = 1; m_busy[c] = 0; end
            end
            if (start[c] && !was_busy) begin
               len_c  = int'(len_bus[c*LW +: LW]);
               base_c = int'(base_bus[c*AW +: AW]);
               bank_c = int'(bank_bus[c*BSW +: BSW]);
               m_pkt[c] = pkt_bus[c*PKW +: PKW];
               issued_cnt[c] = 0; popped_cnt[c] = 0;
               if (len_c == 0) done_n = 1;
               else begin
                  m_busy[c] = 1;
                  for (int i = 0; i < len_c; i++) begin
                     exp_q[c].push_back(mem_word(bank_c, (base_c + i) % 512));
                     iss_q[c].push_back(bank_c * 1024 + (base_c + i) % 512);
                  end
               end
            end
            m_done[c] = done_n;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic set_ch(int c, int b, int base, int len, logic [8:0] pkt);
      bank_bus[c*BSW +: BSW] = 2'(b);
      base_bus[c*AW +: AW]   = 9'(base);
      len_bus[c*LW +: LW]    = 10'(len);
      pkt_bus[c*PKW +: PKW]  = pkt;
   endtask

   task automatic wait_done(int c, int max, string tag, output int pops);
      bit seen;
      seen = 0; pops = 0;
      for (int k = 0; k < max && !seen; k++) begin
         @(negedge clk);
         if (valid[c] && ready[c]) pops++;
         if (done[c]) seen = 1;
         tick();
      end
      chk({tag, "_done_seen"}, seen, 1'b1);
   endtask

   task automatic run_single(string tag);
      logic re_l [14];
      logic [8:0] ra_l [14];
      logic v_l [14];
      logic d_l [14];
      logic [31:0] dat_l [14];
      logic [8:0] pk_l [14];
      set_ch(0, 0, 0, 8, {4'd1, 5'd3});
      start[0] = 1'b1;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         re_l[k] = gif.o_glb_re; ra_l[k] = gif.o_glb_ra; v_l[k] = valid[0];
         d_l[k] = done[0]; dat_l[k] = data_o[0 +: DW]; pk_l[k] = pkt_o[0 +: PKW];
         tick();
         start[0] = 1'b0;
      end
      for (int k = 0; k < 14; k++) begin
         chk($sformatf("%s_re_c%0d", tag, k), re_l[k], (k >= 1 && k <= 8));
         if (k >= 1 && k <= 8) chk($sformatf("%s_ra_c%0d", tag, k), ra_l[k], 9'(k - 1));
         chk($sformatf("%s_valid_c%0d", tag, k), v_l[k], (k >= 3 && k <= 10));
         if (k >= 3 && k <= 10) chk($sformatf("%s_data_c%0d", tag, k), dat_l[k], 32'hA000_0000 + 32'(k - 3));
         chk($sformatf("%s_done_c%0d", tag, k), d_l[k], (k == 11));
      end
      chk({tag, "_packet"}, pk_l[3], 9'h023);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int n;
      int pops;
      bit seen0, seen1;
      logic d1_l [4];
      // 1: reset with a start strobe that must be ignored
      rst = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (k == 3) begin set_ch(0, 0, 0, 8, 9'h023); start[0] = 1'b1; end
         tick();
      end
      rst = 1'b0; start = '0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t1_idle", {valid, busy, done, gif.o_glb_re}, '0);
         tick();
      end

      // 2: single channel streaming
      run_single("t2");

      // 3: backpressure
      ready[0] = 1'b0;
      set_ch(0, 0, 0, 8, 9'h023);
      start[0] = 1'b1;
      n = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (gif.o_glb_re) n++;
         tick();
         start[0] = 1'b0;
      end
      chk("t3_reads_stalled", n, 4);
      @(negedge clk);
      chk("t3_re_low", gif.o_glb_re, 1'b0);
      tick();
      ready[0] = 1'b1;
      wait_done(0, 40, "t3", pops);
      chk("t3_words", pops, 8);

      // 4: round-robin between ch0 and ch1
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      grant_log.delete();
      set_ch(0, 0, 0, 4, 9'h011);
      set_ch(1, 1, 16, 4, 9'h045);
      start[0] = 1'b1; start[1] = 1'b1;
      tick();
      start = '0;
      seen0 = 0; seen1 = 0;
      for (int k = 0; k < 30 && !(seen0 && seen1); k++) begin
         @(negedge clk);
         if (done[0]) seen0 = 1;
         if (done[1]) seen1 = 1;
         tick();
      end
      chk("t4_done_both", {seen0, seen1}, 2'b11);
      chk("t4_grants", grant_log.size(), 8);
      for (int k = 0; k < grant_log.size() && k < 8; k++)
         chk($sformatf("t4_grant%0d", k), grant_log[k], k % 2);

      // 5: address wrap on ch2, zero-length on ch1
      ra_log.delete();
      set_ch(2, 2, 510, 4, 9'h1FF);
      start[2] = 1'b1;
      tick();
      start = '0;
      wait_done(2, 30, "t5", pops);
      chk("t5_nreads", ra_log.size(), 4);
      if (ra_log.size() == 4) begin
         chk("t5_ra0", ra_log[0], 510);
         chk("t5_ra1", ra_log[1], 511);
         chk("t5_ra2", ra_log[2], 0);
         chk("t5_ra3", ra_log[3], 1);
      end
      ra_log.delete();
      set_ch(1, 1, 5, 0, 9'h000);
      start[1] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         d1_l[k] = done[1];
         chk($sformatf("t5_len0_busy%0d", k), busy[1], 1'b0);
         tick();
         start[1] = 1'b0;
      end
      for (int k = 0; k < 4; k++) chk($sformatf("t5_len0_done_c%0d", k), d1_l[k], (k == 1));
      chk("t5_len0_reads", ra_log.size(), 0);

      // 6: mid-run reset, then a fresh transfer
      set_ch(0, 0, 0, 8, 9'h023);
      start[0] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (k == 1) chk("t6_first_read", gif.o_glb_re, 1'b1);
         tick();
         start[0] = 1'b0;
      end
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk($sformatf("t6_flushed%0d", k), {valid, busy, done}, '0);
         tick();
      end
      run_single("t6");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
